// File: rtl/cpu_control_sequencer.sv
// Hardwired T-state control unit for the bus-based CPU datapath; outputs are pure decodes of state and opcode.
// Latency: fetch 3 cycles, ALU/imm/ldi 6, ld/st 8; T1, ld T6 and st T7 stall while mem_ready is low.
module cpu_control_sequencer #(
   parameter logic [4:0] ALU_ADD = 5'b00011,
   parameter logic [4:0] ALU_AND = 5'b00101,
   parameter logic [4:0] ALU_OR  = 5'b00110
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic        pc_out,
   output logic        pc_in,
   output logic        inc_pc,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        zlow_out,
   output logic        mdr_out,
   output logic        c_out,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        r_in,
   output logic        r_out,
   output logic        ba_out,
   output logic        read,
   output logic        write,
   output logic [4:0]  alu_select,
   output logic        run,
   output logic        illegal
);

   typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

   state_t     state, state_nxt;
   logic [4:0] opcode;
   logic       op_ld, op_ldi, op_st, op_alu, op_imm, op_nop, op_halt;
   logic       op_mem, op_addr, op_illegal;
   logic [4:0] imm_alu;
   logic       unused_ir;

   assign opcode     = ir[31:27];
   assign unused_ir  = ^ir[26:0];
   assign op_ld      = (opcode == 5'h00);
   assign op_ldi     = (opcode == 5'h01);
   assign op_st      = (opcode == 5'h02);
   assign op_alu     = (opcode >= 5'h03) && (opcode <= 5'h0B);
   assign op_imm     = (opcode >= 5'h0C) && (opcode <= 5'h0E);
   assign op_nop     = (opcode == 5'h1E);
   assign op_halt    = (opcode == 5'h1F);
   assign op_mem     = op_ld | op_st;
   assign op_addr    = op_ld | op_ldi | op_st;
   assign op_illegal = !(op_addr | op_alu | op_imm | op_nop | op_halt);

   always_comb begin
      imm_alu = ALU_ADD;
      case (opcode)
         5'h0D:   imm_alu = ALU_AND;
         5'h0E:   imm_alu = ALU_OR;
         default: imm_alu = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pc_out     = 1'b0;
      pc_in      = 1'b0;
      inc_pc     = 1'b0;
      ir_in      = 1'b0;
      y_in       = 1'b0;
      z_in       = 1'b0;
      mar_in     = 1'b0;
      mdr_in     = 1'b0;
      zlow_out   = 1'b0;
      mdr_out    = 1'b0;
      c_out      = 1'b0;
      gra        = 1'b0;
      grb        = 1'b0;
      grc        = 1'b0;
      r_in       = 1'b0;
      r_out      = 1'b0;
      ba_out     = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      alu_select = ALU_ADD;
      run        = 1'b0;
      illegal    = 1'b0;
      case (state)
         IDLE: state_nxt = T0;
         T0: begin
            run = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            state_nxt = T1;
         end
         T1: begin
            run = 1'b1; zlow_out = 1'b1; read = 1'b1; mdr_in = 1'b1;
            // PC takes the incremented value only once the fetch completes
            if (mem_ready) begin
               pc_in     = 1'b1;
               state_nxt = T2;
            end
         end
         T2: begin
            run = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            state_nxt = op_nop ? T0 : T3;
         end
         T3: begin
            run = 1'b1;
            if (op_alu || op_imm) begin
               grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
               state_nxt = T4;
            end else if (op_addr) begin
               grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
               state_nxt = T4;
            end else if (op_halt) begin
               state_nxt = HALT;
            end else begin
               illegal   = op_illegal;
               state_nxt = T0;
            end
         end
         T4: begin
            run = 1'b1; z_in = 1'b1;
            if (op_alu) begin
               grc = 1'b1; r_out = 1'b1; alu_select = opcode;
            end else begin
               c_out = 1'b1;
               if (op_imm) alu_select = imm_alu;
            end
            state_nxt = T5;
         end
         T5: begin
            run = 1'b1; zlow_out = 1'b1;
            if (op_mem) begin
               mar_in    = 1'b1;
               state_nxt = T6;
            end else begin
               gra = 1'b1; r_in = 1'b1;
               state_nxt = T0;
            end
         end
         T6: begin
            run = 1'b1; mdr_in = 1'b1;
            if (op_ld) begin
               read = 1'b1;
               if (mem_ready) state_nxt = T7;
            end else begin
               gra = 1'b1; r_out = 1'b1;
               state_nxt = T7;
            end
         end
         T7: begin
            run = 1'b1;
            if (op_ld) begin
               mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
               state_nxt = T0;
            end else begin
               write = 1'b1;
               if (mem_ready) state_nxt = T0;
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Hardwired multi-cycle control unit for the 32-bit bus-based CPU datapath. It holds the register file, PC, IR, Y, Z, MAR, MDR, bus mux and ALU.
- Steps a T-state FSM through fetch and execute for load, store, register ALU, immediate ALU, nop and halt instructions.
- Drives every register-enable, bus-source and ALU-select line.
- Waits on a memory-ready handshake for each read and write.
- Register-field decode and bus-select encoding stay outside this block; it emits only Gra/Grb/Grc/Rin/Rout/BAout.

Parameters:
ALU_ADD, 5'b00011, ALU_select code for address and immediate add
ALU_AND, 5'b00101, ALU_select code used by andi
ALU_OR, 5'b00110, ALU_select code used by ori

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
ir  in  32  IR register output; opcode ir[31:27]; ra [26:23], rb [22:19], rc [18:15], C [18:0]
mem_ready  in  1  memory has completed the current read or write
pc_out, pc_in, inc_pc  out  1 each  PC to bus, PC load, PC increment select
ir_in, y_in, z_in, mar_in, mdr_in  out  1 each  register load enables
zlow_out, mdr_out, c_out  out  1 each  bus source selects (c_out = sign-extended C)
gra, grb, grc, r_in, r_out, ba_out  out  1 each  register select/encode controls
read, write  out  1 each  memory strobes; MDR takes memory data when read=1, bus data otherwise
alu_select  out  5  ALU operation
run  out  1  high while executing
illegal  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- State register only; all outputs are combinational decodes of state and ir[31:27].
- States: IDLE, T0–T7, HALT.
- Reset:
  - clr=1 at a clock edge forces IDLE, from any state including mid-memory-wait.
  - In IDLE every output is 0, including run; alu_select=ALU_ADD.
  - IDLE→T0 unconditionally on the next edge.
- Defaults: every output not listed for a state is 0; alu_select=ALU_ADD.
- run=1 in T0–T7.
- Fetch (all opcodes):
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, read, mdr_in; hold T1 while mem_ready=0. Advance on the first edge with mem_ready=1. pc_in asserts only in the cycle mem_ready=1.
  - T2: mdr_out, ir_in.
  - ir is valid from T3 onward.
- Opcode map:
  - 0x00 ld, 0x01 ldi, 0x02 st.
  - 0x03–0x0B register ALU op; alu_select = opcode.
  - 0x0C addi, 0x0D andi, 0x0E ori.
  - 0x1E nop, 0x1F halt.
  - All other opcodes are illegal.
- Register ALU (0x03–0x0B):
  - T3: grb, r_out, y_in.
  - T4: grc, r_out, alu_select=opcode, z_in.
  - T5: zlow_out, gra, r_in; then T0.
- addi/andi/ori:
  - T3: grb, r_out, y_in.
  - T4: c_out, z_in; alu_select = ALU_ADD, ALU_AND or ALU_OR respectively.
  - T5: zlow_out, gra, r_in; then T0.
- ldi:
  - T3: grb, ba_out, y_in.
  - T4: c_out, ALU_ADD, z_in.
  - T5: zlow_out, gra, r_in; then T0.
- ld:
  - T3 and T4 as ldi.
  - T5: zlow_out, mar_in.
  - T6: read, mdr_in; wait on mem_ready as in T1.
  - T7: mdr_out, gra, r_in; then T0.
- st:
  - T3–T5 as ld.
  - T6: gra, r_out, mdr_in (read=0).
  - T7: write; hold while mem_ready=0; then T0.
- nop: T2→T0.
- halt: T3→HALT. HALT is absorbing; all outputs 0, run=0; only clr exits.
- Illegal opcode: illegal=1 during T3 only, no register writes, then T0 (treated as nop).
- Cycle counts with mem_ready held 1:
  - fetch: 3
  - ALU / immediate / ldi: 6 total
  - ld: 8
  - st: 8
  - nop: 3
  - Each mem_ready=0 cycle adds one cycle.
- Never assert more than one bus source (pc_out, zlow_out, mdr_out, c_out, r_out, ba_out) in any state.
- Never assert read and write together.

Test Plan:
- Reset: clr=1 for 2 cycles in any state → next cycle IDLE, all outputs 0. Release → T0 one cycle later, with pc_out=mar_in=inc_pc=z_in=1.
- add r1,r2,r3 (ir=0x18918000, mem_ready=1) → exact 6-cycle sequence T0..T5. In T4, alu_select=5'b00011 and grc=r_out=z_in=1. In T5, gra=r_in=zlow_out=1. Then T0.
- ld with mem_ready=0 for 3 cycles in T1 and 2 cycles in T6 → T1 held 4 cycles with pc_in only on the last; total 13 cycles; r_in only in T7.
- st → T6 has r_out, gra, mdr_in with read=0; T7 has write=1 held until mem_ready. read/write never overlap; at most one bus source per cycle, checked by assertion.
- ori (opcode 0x0E) → T4 has alu_select=ALU_OR and c_out=1. Opcode 0x15 → illegal pulses exactly 1 cycle, no r_in, returns to T0.
- halt → HALT with run=0, stays 20 cycles regardless of mem_ready. clr asserted mid-T6 wait on ld → IDLE next edge, read drops to 0.
